// File: rtl/frog_game_fsm_pkg.sv
// Shared constants and types for the frog game-flow controller.
// Optional feature macro: FROG_INVULN_EN (see frog_game_fsm.sv).
package frog_game_fsm_pkg;

    // State encodings seen on o_State
    localparam logic [2:0] C_ST_IDLE = 3'd0;
    localparam logic [2:0] C_ST_PLAY = 3'd1;
    localparam logic [2:0] C_ST_HIT  = 3'd2;
    localparam logic [2:0] C_ST_WIN  = 3'd3;
    localparam logic [2:0] C_ST_OVER = 3'd4;

    localparam logic [8:0] C_GOAL_Y    = 9'd0;
    localparam int         C_NUM_LIVES = 3;

    // Width of the frame/guard counters; holds every load value in use
    localparam int CNT_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE = C_ST_IDLE,
        ST_PLAY = C_ST_PLAY,
        ST_HIT  = C_ST_HIT,
        ST_WIN  = C_ST_WIN,
        ST_OVER = C_ST_OVER
    } state_e;

    function automatic logic [2:0] sat_dec3(input logic [2:0] v);
        return (v == 3'd0) ? 3'd0 : v - 3'd1;
    endfunction

    function automatic logic [3:0] sat_inc4(input logic [3:0] v);
        return (v == 4'd15) ? 4'd15 : v + 4'd1;
    endfunction

endpackage

// File: rtl/frog_game_fsm_if.sv
// Signal bundle between the game-flow controller and its neighbours.
// o_Invuln only exists when FROG_INVULN_EN is defined.
interface frog_game_fsm_if;
    logic       i_Frame_Tick;
    logic       i_Start;
    logic       i_Has_Collided;
    logic [8:0] i_Frog_Y;
    logic [2:0] o_State;
    logic [2:0] o_Lives;
    logic [3:0] o_Level;
    logic       o_Respawn;
    logic       o_Freeze;
`ifdef FROG_INVULN_EN
    logic       o_Invuln;

    modport master (
        output i_Frame_Tick, i_Start, i_Has_Collided, i_Frog_Y,
        input  o_State, o_Lives, o_Level, o_Respawn, o_Freeze, o_Invuln
    );
    modport slave (
        input  i_Frame_Tick, i_Start, i_Has_Collided, i_Frog_Y,
        output o_State, o_Lives, o_Level, o_Respawn, o_Freeze, o_Invuln
    );
`else
    modport master (
        output i_Frame_Tick, i_Start, i_Has_Collided, i_Frog_Y,
        input  o_State, o_Lives, o_Level, o_Respawn, o_Freeze
    );
    modport slave (
        input  i_Frame_Tick, i_Start, i_Has_Collided, i_Frog_Y,
        output o_State, o_Lives, o_Level, o_Respawn, o_Freeze
    );
`endif
endinterface

// File: rtl/frog_game_fsm_frame_countdown.sv
// Loadable down-counter stepped by the frame tick; load wins over tick,
// so a tick coinciding with the load is dropped.
import frog_game_fsm_pkg::*;

module frame_countdown #(
    parameter int W = CNT_W
) (
    input  logic         i_Clk,
    input  logic         i_Reset,
    input  logic         i_Load,
    input  logic [W-1:0] i_Load_Val,
    input  logic         i_Tick,
    output logic         o_Zero
);
    logic [W-1:0] cnt_q;

    // Counter register: reset, load, or tick-driven decrement down to zero
    always_ff @(posedge i_Clk) begin
        if (i_Reset)
            cnt_q <= '0;
        else if (i_Load)
            cnt_q <= i_Load_Val;
        else if (i_Tick && cnt_q != '0)
            cnt_q <= cnt_q - 1'b1;
    end

    assign o_Zero = (cnt_q == '0);
endmodule

// File: rtl/frog_game_fsm.sv
// Game-flow controller: lives, level, play/hit/win/over sequencing,
// respawn pulse and freeze gating. All outputs are registered.
// Optional feature macro: FROG_INVULN_EN adds a post-respawn
// invulnerability window and the o_Invuln output.
import frog_game_fsm_pkg::*;

module frog_game_fsm #(
    parameter int         NUM_LIVES     = C_NUM_LIVES,
    parameter int         HIT_FRAMES    = 60,
    parameter int         WIN_FRAMES    = 30,
    parameter logic [8:0] GOAL_Y        = C_GOAL_Y,
    parameter int         GUARD_CYCLES  = 2
`ifdef FROG_INVULN_EN
    ,parameter int        INVULN_FRAMES = 90
`endif
) (
    input  logic            i_Clk,
    input  logic            i_Reset,
    frog_game_fsm_if.slave  bus
);
    state_e             state_q, state_d;
    logic [2:0]         lives_q, lives_d;
    logic [3:0]         level_q, level_d;
    logic [CNT_W-1:0]   guard_q, guard_d;
    logic               respawn_q, respawn_d;
    logic               freeze_q, freeze_d;
    logic               fc_load;
    logic [CNT_W-1:0]   fc_val;
    logic               fc_zero;
    logic               coll_masked;

    // Shared HIT/WIN countdown
    frame_countdown #(.W(CNT_W)) u_frame_cd (
        .i_Clk      (i_Clk),
        .i_Reset    (i_Reset),
        .i_Load     (fc_load),
        .i_Load_Val (fc_val),
        .i_Tick     (bus.i_Frame_Tick),
        .o_Zero     (fc_zero)
    );

`ifdef FROG_INVULN_EN
    logic inv_zero;

    // Every entry into PLAY carries a respawn, so that pulse reloads the window
    frame_countdown #(.W(CNT_W)) u_invuln_cd (
        .i_Clk      (i_Clk),
        .i_Reset    (i_Reset),
        .i_Load     (respawn_d),
        .i_Load_Val (CNT_W'(INVULN_FRAMES)),
        .i_Tick     (bus.i_Frame_Tick),
        .o_Zero     (inv_zero)
    );

    assign coll_masked  = (guard_q != '0) || !inv_zero;
    assign bus.o_Invuln = !inv_zero;
`else
    assign coll_masked  = (guard_q != '0);
`endif

    // State and game-progress registers
    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            state_q   <= ST_IDLE;
            lives_q   <= 3'(NUM_LIVES);
            level_q   <= 4'd0;
            guard_q   <= '0;
            respawn_q <= 1'b0;
            freeze_q  <= 1'b1;
        end else begin
            state_q   <= state_d;
            lives_q   <= lives_d;
            level_q   <= level_d;
            guard_q   <= guard_d;
            respawn_q <= respawn_d;
            freeze_q  <= freeze_d;
        end
    end

    // Next-state, counter loads and respawn decision
    always_comb begin
        state_d   = state_q;
        lives_d   = lives_q;
        level_d   = level_q;
        guard_d   = guard_q;
        respawn_d = 1'b0;
        fc_load   = 1'b0;
        fc_val    = '0;

        if (state_q == ST_PLAY && guard_q != '0)
            guard_d = guard_q - 1'b1;

        case (state_q)
            ST_IDLE, ST_OVER: begin
                if (bus.i_Start) begin
                    state_d   = ST_PLAY;
                    respawn_d = 1'b1;
                    lives_d   = 3'(NUM_LIVES);
                    level_d   = 4'd0;
                    guard_d   = CNT_W'(GUARD_CYCLES);
                end
            end
            ST_PLAY: begin
                // Collision is checked first so it beats a same-cycle goal
                if (!coll_masked && bus.i_Has_Collided) begin
                    state_d = ST_HIT;
                    lives_d = sat_dec3(lives_q);
                    fc_load = 1'b1;
                    fc_val  = CNT_W'(HIT_FRAMES);
                end else if (bus.i_Frog_Y == GOAL_Y) begin
                    state_d = ST_WIN;
                    level_d = sat_inc4(level_q);
                    fc_load = 1'b1;
                    fc_val  = CNT_W'(WIN_FRAMES);
                end
            end
            ST_HIT: begin
                if (fc_zero) begin
                    if (lives_q == 3'd0) begin
                        state_d = ST_OVER;
                    end else begin
                        state_d   = ST_PLAY;
                        respawn_d = 1'b1;
                        guard_d   = CNT_W'(GUARD_CYCLES);
                    end
                end
            end
            ST_WIN: begin
                if (fc_zero) begin
                    state_d   = ST_PLAY;
                    respawn_d = 1'b1;
                    guard_d   = CNT_W'(GUARD_CYCLES);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign freeze_d      = (state_d != ST_PLAY);

    assign bus.o_State   = state_q;
    assign bus.o_Lives   = lives_q;
    assign bus.o_Level   = level_q;
    assign bus.o_Respawn = respawn_q;
    assign bus.o_Freeze  = freeze_q;
endmodule

// File: doc/frog_game_fsm.md
Name: frog_game_fsm

Overview:
- Game-flow controller directly downstream of the car/frog collision checker; consumes its registered collision flag and the frog's Y position.
- Tracks lives and level, and decides when the game is playing, frozen after a hit, celebrating a crossing, or over.
- Drives a respawn pulse to the frog position block and a freeze flag that gates frog input and car motion.
- Shared C_ constants come from Constants.v.

Parameters:
- NUM_LIVES, 3, lives loaded at game start; range 1..7.
- HIT_FRAMES, 60, frames frozen after a collision.
- WIN_FRAMES, 30, frames frozen after reaching the goal row.
- GOAL_Y, 0, frog Y (pixels) counted as a successful crossing.
- GUARD_CYCLES, 2, clock cycles after entering PLAY during which i_Has_Collided is ignored; covers the collision checker's registered latency after respawn.

Ports:
- i_Clk  in  1  system clock.
- i_Reset  in  1  synchronous, active-high reset.
- i_Frame_Tick  in  1  one-cycle pulse per video frame.
- i_Start  in  1  start/restart request, level-sensitive.
- i_Has_Collided  in  1  registered collision flag from the collision stage.
- i_Frog_Y  in  9  frog top-left Y in pixels.
- o_State  out  3  0=IDLE 1=PLAY 2=HIT 3=WIN 4=OVER.
- o_Lives  out  3  remaining lives.
- o_Level  out  4  completed crossings, saturating.
- o_Respawn  out  1  one-cycle pulse: place the frog at its start tile.
- o_Freeze  out  1  high in every state except PLAY.

Behaviour:
- Reset values: o_State=IDLE, o_Lives=NUM_LIVES, o_Level=0, o_Respawn=0, o_Freeze=1, frame counter=0, guard counter=0.
- All outputs are registered. State changes take effect the cycle after the triggering input is sampled.
- IDLE: if i_Start, go to PLAY; o_Respawn=1 for that one cycle; lives=NUM_LIVES; level=0; guard=GUARD_CYCLES.
- PLAY:
  - Guard counter decrements each cycle while >0.
  - If guard==0 and i_Has_Collided: go to HIT, lives-=1 (saturate at 0), frame counter=HIT_FRAMES.
  - Else if i_Frog_Y==GOAL_Y: go to WIN, level+=1 (saturate at 15), frame counter=WIN_FRAMES.
  - Collision and goal in the same cycle: collision wins, level unchanged.
- HIT and WIN (frame counter):
  - Decrements on i_Frame_Tick while >0.
  - A tick in the cycle the counter is loaded is ignored.
  - The counter is tested every cycle. With HIT_FRAMES=0 or WIN_FRAMES=0, exit happens the next cycle.
- HIT exit (counter==0): if lives==0, go to OVER with no respawn; else go to PLAY, o_Respawn pulse, guard reloaded.
- WIN exit (counter==0): go to PLAY, o_Respawn pulse, guard reloaded; lives unchanged.
- OVER: outputs hold. If i_Start, behave as IDLE+start: lives=NUM_LIVES, level=0, respawn pulse, go to PLAY.
- i_Start is ignored in PLAY, HIT and WIN.
- i_Reset asserted in any state, including mid-countdown, returns every register to its reset value on the next edge. Reset takes priority over all inputs.
- o_Respawn is never high for two consecutive cycles.

Optional Feature:
- Macro: FROG_INVULN_EN.
- Defined: adds parameter INVULN_FRAMES (default 90). On each return to PLAY, an invulnerability counter is loaded and decrements on i_Frame_Tick. Collisions are ignored while it or the guard counter is nonzero. An extra output o_Invuln (1 bit, high while the counter is nonzero, reset 0) lets the renderer blink the frog.
- Undefined: only the GUARD_CYCLES mask applies; there is no o_Invuln port.

Decomposition:
- Constants.v gains the state encodings C_ST_IDLE..C_ST_OVER, C_GOAL_Y and C_NUM_LIVES; top-level instantiation uses these.
- One sub-module: frame_countdown. It takes a load value and a tick, exposes a zero flag, and is instantiated once for the HIT/WIN countdown and, under FROG_INVULN_EN, again for invulnerability.

Test Plan:
- Reset, then i_Start=1 for 1 cycle -> next cycle State=1, o_Respawn=1 for exactly 1 cycle, Lives=3, Level=0, Freeze=0.
- In PLAY, pulse i_Has_Collided 1 cycle after the guard expires -> State=2, Lives=2, Freeze=1. After 60 frame ticks -> State=1 with respawn pulse. Collision held during the 2 guard cycles -> no HIT.
- Three collisions in a row -> Lives 2,1,0. After the third HIT countdown -> State=4, no respawn. i_Start -> State=1, Lives=3, Level=0.
- i_Frog_Y=0 in PLAY -> State=3, Level=1. After 30 ticks -> PLAY with respawn. Repeat 20 crossings -> Level saturates at 15.
- Collision and i_Frog_Y=0 in the same cycle -> State=2, Level unchanged, Lives decremented. i_Reset at tick 10 of a HIT countdown -> all outputs return to reset values next cycle.
- FROG_INVULN_EN defined: collision within 90 frames of respawn -> ignored, o_Invuln=1. Collision at frame 91 -> HIT.
